alu_seq_unit: RTL and testbench

Parametrised, handshaked ALU execution unit with decode, single-cycle arithmetic/logic, and a low-area iterative shifter that shifts 1 bit per cycle. It extends the basic 6-op opcode set with XOR, arithmetic shift right, status flags and illegal-opcode reporting. It sits between the instruction issue stage (upstream, valid/ready) and writeback (downstream, valid/ready). It holds one operation in flight at a time.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_seq_unit_if.sv | 34 +++
 rtl/alu_serial_shifter.sv | 77 +++++++
 rtl/alu_seq_unit.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU execution unit.
//   - opcode constants (4-bit encodings; wider opcode fields must be zero above bit 3)
//   - FSM state encoding
//   - serial shifter direction encoding
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_OR  = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_SHL = 4'h4;
   localparam logic [3:0] OP_SHR = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_SRA = 4'h7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SH_LEFT   = 2'd0,   // logical left, zero fill
      SH_RLOG   = 2'd1,   // logical right, zero fill
      SH_RARITH = 2'd2    // arithmetic right, MSB replicated
   } shdir_t;

endpackage

// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if: issue-side and writeback-side handshake bundle.
//   master : the environment (issue stage + writeback stage)
//   slave  : the execution unit
// Handshake rules: a transfer happens on a rising edge where valid & ready are
// both high. A source holds valid and its data stable until that edge; ready
// may be low for any number of cycles. in_* carries one operation upstream,
// out_* carries one result downstream; busy reports a non-idle unit.
interface alu_seq_unit_if #(
   parameter int DATA_WIDTH = 8,
   parameter int OP_WIDTH   = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [OP_WIDTH-1:0]   in_opcode;
   logic [DATA_WIDTH-1:0] in_a;
   logic [DATA_WIDTH-1:0] in_b;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_result;
   logic                  out_carry;
   logic                  out_zero;
   logic                  out_illegal;
   logic                  busy;

   modport master (
      output in_valid, in_opcode, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_carry, out_zero, out_illegal, busy
   );

   modport slave (
      input  in_valid, in_opcode, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_carry, out_zero, out_illegal, busy
   );
endinterface

// File: rtl/alu_serial_shifter.sv
// alu_serial_shifter: 1 bit per cycle shift register with down-counter.
// Ports:
//   clk, rst        clock, async active-high reset
//   i_load          load i_value / i_amount / i_mode (takes priority)
//   i_value         value to shift
//   i_amount        number of single-bit steps
//   i_mode          shift direction (shdir_t)
//   o_next_value    value after the step performed at the coming edge
//   o_next_bit      bit shifted out by that step
//   o_last          the coming edge performs the final step (count == 1)
//   o_done          no steps remaining (count == 0)
module alu_serial_shifter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int SHW        = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_value,
   input  logic [SHW-1:0]        i_amount,
   input  shdir_t                i_mode,
   output logic [DATA_WIDTH-1:0] o_next_value,
   output logic                  o_next_bit,
   output logic                  o_last,
   output logic                  o_done
);
   logic [DATA_WIDTH-1:0] r_value;
   logic [SHW-1:0]        r_count;
   shdir_t                r_mode;
   logic [DATA_WIDTH-1:0] w_next_value;
   logic                  w_next_bit;

   always_comb begin
      w_next_value = r_value;
      w_next_bit   = 1'b0;
      case (r_mode)
         SH_LEFT: begin
            w_next_value = {r_value[DATA_WIDTH-2:0], 1'b0};
            w_next_bit   = r_value[DATA_WIDTH-1];
         end
         SH_RLOG: begin
            w_next_value = {1'b0, r_value[DATA_WIDTH-1:1]};
            w_next_bit   = r_value[0];
         end
         SH_RARITH: begin
            w_next_value = {r_value[DATA_WIDTH-1], r_value[DATA_WIDTH-1:1]};
            w_next_bit   = r_value[0];
         end
         default: begin
            w_next_value = r_value;
            w_next_bit   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_value <= '0;
         r_count <= '0;
         r_mode  <= SH_LEFT;
      end else if (i_load) begin
         r_value <= i_value;
         r_count <= i_amount;
         r_mode  <= i_mode;
      end else if (r_count != '0) begin
         r_value <= w_next_value;
         r_count <= r_count - SHW'(1);
      end
   end

   assign o_next_value = w_next_value;
   assign o_next_bit   = w_next_bit;
   assign o_last       = (r_count == SHW'(1));
   assign o_done       = (r_count == '0);
endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU execution unit, one operation in flight.
// Single-cycle ADD/SUB/OR/AND/XOR, iterative SHL/SHR/SRA (1 bit per cycle),
// carry/zero/illegal status.
// Ports:
//   clk, rst   clock, async active-high reset
//   alu_if     slave side of alu_seq_unit_if (issue in, result out, busy)
//   o_state    current FSM state, for observation
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OP_WIDTH   = 4
) (
   input  logic           clk,
   input  logic           rst,
   alu_seq_unit_if.slave  alu_if,
   output state_t         o_state
);
   localparam int SHW = $clog2(DATA_WIDTH);

   state_t                r_state;
   state_t                w_state_next;
   logic                  w_in_ready;
   logic                  w_out_valid;
   logic                  w_busy;
   logic                  w_accept;

   logic [3:0]            w_op4;
   logic                  w_legal;
   logic                  w_is_shift;
   logic [SHW-1:0]        w_shamt;
   shdir_t                w_sh_mode;
   logic [DATA_WIDTH:0]   w_sum;
   logic [DATA_WIDTH:0]   w_diff;

   logic                  w_sh_load;
   logic [DATA_WIDTH-1:0] w_sh_next_value;
   logic                  w_sh_next_bit;
   logic                  w_sh_last;
   logic                  w_sh_done;

   logic                  w_load_out;
   logic [DATA_WIDTH-1:0] w_res_d;
   logic                  w_carry_d;
   logic                  w_ill_d;

   logic [DATA_WIDTH-1:0] r_result;
   logic                  r_carry;
   logic                  r_zero;
   logic                  r_illegal;

   // ---------------- decode ----------------
   // Legal codes are 0..7; this also rejects any set bit above bit 3.
   assign w_op4   = alu_if.in_opcode[3:0];
   assign w_legal = (alu_if.in_opcode <= OP_WIDTH'(OP_SRA));
   assign w_shamt = alu_if.in_b[SHW-1:0];

   always_comb begin
      w_is_shift = 1'b0;
      w_sh_mode  = SH_LEFT;
      case (w_op4)
         OP_SHL: begin w_is_shift = w_legal; w_sh_mode = SH_LEFT;   end
         OP_SHR: begin w_is_shift = w_legal; w_sh_mode = SH_RLOG;   end
         OP_SRA: begin w_is_shift = w_legal; w_sh_mode = SH_RARITH; end
         default: begin w_is_shift = 1'b0;   w_sh_mode = SH_LEFT;   end
      endcase
   end

   // Extra MSB gives carry-out for ADD and borrow for SUB.
   assign w_sum  = {1'b0, alu_if.in_a} + {1'b0, alu_if.in_b};
   assign w_diff = {1'b0, alu_if.in_a} - {1'b0, alu_if.in_b};

   assign w_accept  = alu_if.in_valid & w_in_ready;
   assign w_sh_load = w_accept & w_is_shift & (w_shamt != '0);

   // ---------------- serial shifter ----------------
   alu_serial_shifter #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHW        (SHW)
   ) u_shifter (
      .clk          (clk),
      .rst          (rst),
      .i_load       (w_sh_load),
      .i_value      (alu_if.in_a),
      .i_amount     (w_shamt),
      .i_mode       (w_sh_mode),
      .o_next_value (w_sh_next_value),
      .o_next_bit   (w_sh_next_bit),
      .o_last       (w_sh_last),
      .o_done       (w_sh_done)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_next = w_sh_load ? ST_SHIFT : ST_DONE;
         end
         // Leave on the edge that performs the final step, so the result is
         // registered on that same edge (k shift cycles for a shift by k).
         ST_SHIFT: begin
            if (w_sh_last || w_sh_done) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            if (alu_if.out_ready) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = ~rst;
            w_busy     = 1'b0;
         end
         ST_SHIFT: w_busy = 1'b1;
         ST_DONE:  w_out_valid = 1'b1;
         default:  w_busy = 1'b0;
      endcase
   end

   // ---------------- result datapath ----------------
   always_comb begin
      w_load_out = 1'b0;
      w_res_d    = '0;
      w_carry_d  = 1'b0;
      w_ill_d    = 1'b0;
      if (r_state == ST_IDLE && w_accept) begin
         if (!w_legal) begin
            w_load_out = 1'b1;
            w_ill_d    = 1'b1;
         end else if (w_is_shift) begin
            // Zero-length shift completes immediately with A unchanged.
            if (w_shamt == '0) begin
               w_load_out = 1'b1;
               w_res_d    = alu_if.in_a;
            end
         end else begin
            w_load_out = 1'b1;
            case (w_op4)
               OP_ADD: begin w_res_d = w_sum[DATA_WIDTH-1:0];  w_carry_d = w_sum[DATA_WIDTH];  end
               OP_SUB: begin w_res_d = w_diff[DATA_WIDTH-1:0]; w_carry_d = w_diff[DATA_WIDTH]; end
               OP_OR:  w_res_d = alu_if.in_a | alu_if.in_b;
               OP_AND: w_res_d = alu_if.in_a & alu_if.in_b;
               OP_XOR: w_res_d = alu_if.in_a ^ alu_if.in_b;
               default: w_res_d = '0;
            endcase
         end
      end else if (r_state == ST_SHIFT && w_sh_last) begin
         w_load_out = 1'b1;
         w_res_d    = w_sh_next_value;
         w_carry_d  = w_sh_next_bit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result  <= '0;
         r_carry   <= 1'b0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
      end else if (w_load_out) begin
         r_result  <= w_res_d;
         r_carry   <= w_carry_d;
         r_zero    <= (w_res_d == '0);
         r_illegal <= w_ill_d;
      end
   end

   assign alu_if.in_ready    = w_in_ready;
   assign alu_if.out_valid   = w_out_valid;
   assign alu_if.busy        = w_busy;
   assign alu_if.out_result  = r_result;
   assign alu_if.out_carry   = r_carry;
   assign alu_if.out_zero    = r_zero;
   assign alu_if.out_illegal = r_illegal;
   assign o_state            = r_state;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed + randomized check of alu_seq_unit (DATA_WIDTH=8)
// against an arithmetic reference model and an expected-result queue.
module tb_alu_seq_unit;
   import alu_pkg::*;

   localparam int W   = 8;
   localparam int OPW = 4;

   logic   clk = 1'b0;
   logic   rst;
   state_t w_state;

   alu_seq_unit_if #(.DATA_WIDTH(W), .OP_WIDTH(OPW)) u_if ();

   alu_seq_unit #(.DATA_WIDTH(W), .OP_WIDTH(OPW)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .alu_if  (u_if),
      .o_state (w_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // {illegal, zero, carry, result}
   logic [W+2:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   task automatic ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] res, output logic c, output logic ill,
                            output int lat);
      int ai, bi, k, t;
      ai  = int'(a);
      bi  = int'(b);
      k   = bi % W;
      res = '0;
      c   = 1'b0;
      ill = 1'b0;
      lat = 1;
      case (op)
         4'h0: begin t = ai + bi; res = W'(t); c = (t >= (1 << W)); end
         4'h1: begin res = W'(ai - bi); c = (ai < bi); end
         4'h2: res = W'(ai | bi);
         4'h3: res = W'(ai & bi);
         4'h6: res = W'(ai ^ bi);
         4'h4: begin
            res = W'(ai << k);
            c   = (k > 0) && (((ai >> (W - k)) & 1) != 0);
            lat = 1 + k;
         end
         4'h5: begin
            res = W'(ai >> k);
            c   = (k > 0) && (((ai >> (k - 1)) & 1) != 0);
            lat = 1 + k;
         end
         4'h7: begin
            t   = (ai >= (1 << (W - 1))) ? ai - (1 << W) : ai;
            res = W'(t >>> k);
            c   = (k > 0) && (((ai >> (k - 1)) & 1) != 0);
            lat = 1 + k;
         end
         default: ill = 1'b1;
      endcase
   endtask

   // ---------------- driver: one full operation ----------------
   task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
      logic [W-1:0] r;
      logic         c, il;
      int           lat, n;
      logic [W+2:0] e;
      ref_model(op, a, b, r, c, il, lat);
      exp_q.push_back({il, (r == '0), c, r});

      u_if.out_ready = (hold == 0);
      u_if.in_opcode = op;
      u_if.in_a      = a;
      u_if.in_b      = b;
      u_if.in_valid  = 1'b1;
      check("in_ready_idle", u_if.in_ready, 1);
      step();
      // Inputs change after accept; the result must not follow them.
      u_if.in_valid  = 1'b0;
      u_if.in_opcode = 4'($urandom);
      u_if.in_a      = W'($urandom);
      u_if.in_b      = W'($urandom);

      n = 0;
      while (u_if.out_valid !== 1'b1 && n < 40) begin
         check("in_ready_busy", u_if.in_ready, 0);
         step();
         n++;
      end
      e = exp_q.pop_front();
      check("out_valid_seen", (n < 40), 1);
      check("latency", n + 1, lat);
      check("result", u_if.out_result, e[W-1:0]);
      check("carry", u_if.out_carry, e[W]);
      check("zero", u_if.out_zero, e[W+1]);
      check("illegal", u_if.out_illegal, e[W+2]);

      for (int i = 0; i < hold; i++) begin
         u_if.in_valid = 1'b1;   // pending request that must wait
         check("hold_valid", u_if.out_valid, 1);
         check("hold_in_ready", u_if.in_ready, 0);
         check("hold_result", u_if.out_result, e[W-1:0]);
         check("hold_carry", u_if.out_carry, e[W]);
         step();
      end
      u_if.out_ready = 1'b1;
      step();   // handshake edge
      check("post_out_valid", u_if.out_valid, 0);
      check("post_in_ready", u_if.in_ready, 1);
      check("post_busy", u_if.busy, 0);
      u_if.in_valid = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [3:0] rop;
      rst            = 1'b1;
      u_if.in_valid  = 1'b0;
      u_if.out_ready = 1'b0;
      u_if.in_opcode = '0;
      u_if.in_a      = '0;
      u_if.in_b      = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", u_if.out_valid, 0);
      check("rst_in_ready", u_if.in_ready, 0);
      check("rst_busy", u_if.busy, 0);
      check("rst_result", u_if.out_result, 0);
      check("rst_flags", {u_if.out_carry, u_if.out_zero, u_if.out_illegal}, 0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Directed cases
      do_op(4'h0, 8'hF0, 8'h20, 0);   // ADD with carry-out
      do_op(4'h1, 8'h05, 8'h05, 0);   // SUB to zero
      do_op(4'h1, 8'h03, 8'h05, 0);   // SUB with borrow
      do_op(4'h5, 8'h0E, 8'h02, 0);   // SHR by 2
      do_op(4'h7, 8'h90, 8'h02, 0);   // SRA by 2
      do_op(4'h4, 8'h81, 8'h00, 0);   // SHL by 0
      do_op(4'h9, 8'h12, 8'h34, 0);   // illegal
      do_op(4'h0, 8'h01, 8'h01, 0);   // ADD after illegal
      do_op(4'h4, 8'h01, 8'h07, 5);   // SHL by 7 with backpressure
      do_op(4'hF, 8'hFF, 8'hFF, 2);   // illegal with backpressure

      // Reset during the 3rd SHIFT cycle of a shift by 6
      u_if.out_ready = 1'b1;
      u_if.in_opcode = 4'h4;
      u_if.in_a      = 8'hA5;
      u_if.in_b      = 8'h06;
      u_if.in_valid  = 1'b1;
      step();
      u_if.in_valid = 1'b0;
      step();
      step();
      check("mid_shift_busy", u_if.busy, 1);
      rst = 1'b1;
      #1;
      check("arst_out_valid", u_if.out_valid, 0);
      check("arst_in_ready", u_if.in_ready, 0);
      check("arst_busy", u_if.busy, 0);
      check("arst_result", u_if.out_result, 0);
      check("arst_flags", {u_if.out_carry, u_if.out_zero, u_if.out_illegal}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("post_rst_out_valid", u_if.out_valid, 0);
         check("post_rst_in_ready", u_if.in_ready, 1);
      end

      // Randomized operations
      for (int i = 0; i < 80; i++) begin
         rop = (($urandom_range(0, 9)) < 8) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
         do_op(rop, W'($urandom), W'($urandom), $urandom_range(0, 2));
      end

      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      n_bad++;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
